alu_reservation_station: RTL and testbench

Holds ALU instructions between the issue stage and the ALU, waits for source operands by snooping the ALU and load/store CDBs, and dispatches one operand-complete entry per cycle into the ALU. Sits directly upstream of the ALU: its dispatch outputs drive the ALU's `_alu_*` inputs, and it respects the ALU's `_alu_full` back-pressure.

---
 rtl/alu_reservation_station_pkg.sv | 52 +++++
 rtl/rs_lowest_picker.sv | 21 ++
 rtl/alu_reservation_station.sv | 146 ++++++++++++++
 tb/tb_alu_reservation_station.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: widths, entry layout, CDB bundle,
// plus the operand snoop helper used by both wake-up and issue bypass.
package alu_reservation_station_pkg;

    localparam int unsigned ROB_W  = 5;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              pending;
        logic [ROB_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } operand_t;

    typedef struct packed {
        logic             busy;
        logic [ROB_W-1:0] rob_id;
        logic [OP_W-1:0]  op;
        operand_t         src1;
        operand_t         src2;
    } rs_entry_t;

    typedef struct packed {
        logic              ready;
        logic [ROB_W-1:0]  rob_id;
        logic [DATA_W-1:0] value;
    } cdb_t;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_id;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
    } alu_payload_t;

    // ALU CDB is checked first so it wins if both buses carry the same tag.
    function automatic operand_t snoop(operand_t opnd, cdb_t alu_cdb, cdb_t lsb_cdb);
        operand_t res;
        res = opnd;
        if (opnd.pending) begin
            if (alu_cdb.ready && alu_cdb.rob_id == opnd.tag) begin
                res.pending = 1'b0;
                res.value   = alu_cdb.value;
            end else if (lsb_cdb.ready && lsb_cdb.rob_id == opnd.tag) begin
                res.pending = 1'b0;
                res.value   = lsb_cdb.value;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_lowest_picker.sv
// Lowest-set-bit priority encoder: reports whether any request is set and the
// index of the lowest one.
module rs_lowest_picker #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req_i,
    output logic                 valid_o,
    output logic [$clog2(N)-1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = ($clog2(N))'(i);
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers issued ALU ops, snoops both CDBs for missing
// operands and dispatches the lowest-index operand-complete entry each cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              _clear,
    input  logic              _issue_valid,
    input  logic [ROB_W-1:0]  _issue_rob_id,
    input  logic [OP_W-1:0]   _issue_op,
    input  logic              _issue_q1_pending,
    input  logic [ROB_W-1:0]  _issue_q1,
    input  logic [DATA_W-1:0] _issue_v1,
    input  logic              _issue_q2_pending,
    input  logic [ROB_W-1:0]  _issue_q2,
    input  logic [DATA_W-1:0] _issue_v2,
    output logic              _rs_full,
    input  logic              _alu_cdb_ready,
    input  logic [ROB_W-1:0]  _alu_cdb_rob_id,
    input  logic [DATA_W-1:0] _alu_cdb_value,
    input  logic              _lsb_cdb_ready,
    input  logic [ROB_W-1:0]  _lsb_cdb_rob_id,
    input  logic [DATA_W-1:0] _lsb_cdb_value,
    input  logic              _alu_full,
    output logic              _alu_ready,
    output logic [ROB_W-1:0]  _alu_rob_id,
    output logic [OP_W-1:0]   _alu_op,
    output logic [DATA_W-1:0] _alu_v1,
    output logic [DATA_W-1:0] _alu_v2
);

    localparam int unsigned IdxW = $clog2(RS_SIZE);

    rs_entry_t    entries_q [RS_SIZE];
    rs_entry_t    entries_d [RS_SIZE];
    alu_payload_t payload_q, payload_d;
    logic         alu_ready_q, alu_ready_d;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] ready_vec;
    logic               free_valid, disp_valid;
    logic [IdxW-1:0]    free_idx, disp_idx;
    cdb_t               alu_cdb, lsb_cdb;
    rs_entry_t          new_entry;

    assign alu_cdb = '{ready: _alu_cdb_ready, rob_id: _alu_cdb_rob_id, value: _alu_cdb_value};
    assign lsb_cdb = '{ready: _lsb_cdb_ready, rob_id: _lsb_cdb_rob_id, value: _lsb_cdb_value};

    // Dispatch eligibility uses registered pending bits only, so a freshly woken
    // operand waits one cycle.
    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            busy[i]      = entries_q[i].busy;
            ready_vec[i] = entries_q[i].busy & ~entries_q[i].src1.pending
                                             & ~entries_q[i].src2.pending;
        end
    end

    assign _rs_full = &busy;

    rs_lowest_picker #(
        .N(RS_SIZE)
    ) u_free_picker (
        .req_i  (~busy),
        .valid_o(free_valid),
        .idx_o  (free_idx)
    );

    rs_lowest_picker #(
        .N(RS_SIZE)
    ) u_disp_picker (
        .req_i  (ready_vec),
        .valid_o(disp_valid),
        .idx_o  (disp_idx)
    );

    always_comb begin
        new_entry        = '0;
        new_entry.busy   = 1'b1;
        new_entry.rob_id = _issue_rob_id;
        new_entry.op     = _issue_op;
        new_entry.src1   = snoop('{pending: _issue_q1_pending, tag: _issue_q1, value: _issue_v1},
                                 alu_cdb, lsb_cdb);
        new_entry.src2   = snoop('{pending: _issue_q2_pending, tag: _issue_q2, value: _issue_v2},
                                 alu_cdb, lsb_cdb);
    end

    always_comb begin
        entries_d   = entries_q;
        payload_d   = payload_q;
        alu_ready_d = 1'b0;

        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (entries_q[i].busy) begin
                entries_d[i].src1 = snoop(entries_q[i].src1, alu_cdb, lsb_cdb);
                entries_d[i].src2 = snoop(entries_q[i].src2, alu_cdb, lsb_cdb);
            end
        end

        if (disp_valid && !_alu_full) begin
            payload_d.rob_id         = entries_q[disp_idx].rob_id;
            payload_d.op             = entries_q[disp_idx].op;
            payload_d.v1             = entries_q[disp_idx].src1.value;
            payload_d.v2             = entries_q[disp_idx].src2.value;
            alu_ready_d              = 1'b1;
            entries_d[disp_idx].busy = 1'b0;
        end

        // The free slot is never busy, so it cannot collide with the dispatched one.
        if (_issue_valid && free_valid) begin
            entries_d[free_idx] = new_entry;
        end

        if (_clear) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entries_d[i].busy = 1'b0;
            end
            alu_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entries_q[i] <= '0;
            end
            payload_q   <= '0;
            alu_ready_q <= 1'b0;
        end else if (rdy_in) begin
            entries_q   <= entries_d;
            payload_q   <= payload_d;
            alu_ready_q <= alu_ready_d;
        end
    end

    assign _alu_ready  = alu_ready_q;
    assign _alu_rob_id = payload_q.rob_id;
    assign _alu_op     = payload_q.op;
    assign _alu_v1     = payload_q.v1;
    assign _alu_v2     = payload_q.v2;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: stimulus pushes expected dispatches,
// a negedge monitor pops and compares each one the ALU would accept.
module tb_alu_reservation_station;

    typedef struct packed {
        logic [4:0]  rob_id;
        logic [2:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        _clear = 1'b0;
    logic        _issue_valid = 1'b0;
    logic [4:0]  _issue_rob_id = '0;
    logic [2:0]  _issue_op = '0;
    logic        _issue_q1_pending = 1'b0;
    logic [4:0]  _issue_q1 = '0;
    logic [31:0] _issue_v1 = '0;
    logic        _issue_q2_pending = 1'b0;
    logic [4:0]  _issue_q2 = '0;
    logic [31:0] _issue_v2 = '0;
    logic        _rs_full;
    logic        _alu_cdb_ready = 1'b0;
    logic [4:0]  _alu_cdb_rob_id = '0;
    logic [31:0] _alu_cdb_value = '0;
    logic        _lsb_cdb_ready = 1'b0;
    logic [4:0]  _lsb_cdb_rob_id = '0;
    logic [31:0] _lsb_cdb_value = '0;
    logic        _alu_full = 1'b0;
    logic        _alu_ready;
    logic [4:0]  _alu_rob_id;
    logic [2:0]  _alu_op;
    logic [31:0] _alu_v1;
    logic [31:0] _alu_v2;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    alu_reservation_station #(
        .RS_SIZE(8)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        ._clear           (_clear),
        ._issue_valid     (_issue_valid),
        ._issue_rob_id    (_issue_rob_id),
        ._issue_op        (_issue_op),
        ._issue_q1_pending(_issue_q1_pending),
        ._issue_q1        (_issue_q1),
        ._issue_v1        (_issue_v1),
        ._issue_q2_pending(_issue_q2_pending),
        ._issue_q2        (_issue_q2),
        ._issue_v2        (_issue_v2),
        ._rs_full         (_rs_full),
        ._alu_cdb_ready   (_alu_cdb_ready),
        ._alu_cdb_rob_id  (_alu_cdb_rob_id),
        ._alu_cdb_value   (_alu_cdb_value),
        ._lsb_cdb_ready   (_lsb_cdb_ready),
        ._lsb_cdb_rob_id  (_lsb_cdb_rob_id),
        ._lsb_cdb_value   (_lsb_cdb_value),
        ._alu_full        (_alu_full),
        ._alu_ready       (_alu_ready),
        ._alu_rob_id      (_alu_rob_id),
        ._alu_op          (_alu_op),
        ._alu_v1          (_alu_v1),
        ._alu_v2          (_alu_v2)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_issue(input logic [4:0] rob, input logic [2:0] op,
                             input logic p1, input logic [4:0] q1, input logic [31:0] v1,
                             input logic p2, input logic [4:0] q2, input logic [31:0] v2);
        _issue_valid      = 1'b1;
        _issue_rob_id     = rob;
        _issue_op         = op;
        _issue_q1_pending = p1;
        _issue_q1         = q1;
        _issue_v1         = v1;
        _issue_q2_pending = p2;
        _issue_q2         = q2;
        _issue_v2         = v2;
    endtask

    // A dispatch counts once: when _alu_ready is seen with rdy_in high.
    always @(negedge clk_in) begin
        if (!rst_in && _alu_ready && rdy_in) begin
            exp_t got;
            got = '{rob_id: _alu_rob_id, op: _alu_op, v1: _alu_v1, v2: _alu_v2};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dispatch: got rob %0d v1 %0h v2 %0h expected none",
                         _alu_rob_id, _alu_v1, _alu_v2);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL dispatch: got rob %0d op %0d v1 %0h v2 %0h expected rob %0d op %0d v1 %0h v2 %0h",
                             got.rob_id, got.op, got.v1, got.v2, e.rob_id, e.op, e.v1, e.v2);
                end
            end
        end
    end

    initial begin
        tick();
        tick();
        rst_in = 1'b0;
        check("reset_alu_ready", 64'(_alu_ready), 64'd0);
        check("reset_rob_id", 64'(_alu_rob_id), 64'd0);
        check("reset_op", 64'(_alu_op), 64'd0);
        check("reset_v1", 64'(_alu_v1), 64'd0);
        check("reset_v2", 64'(_alu_v2), 64'd0);
        check("reset_rs_full", 64'(_rs_full), 64'd0);

        // Basic dispatch
        set_issue(5'd3, 3'd0, 1'b0, 5'd0, 32'd5, 1'b0, 5'd0, 32'd7);
        sb_q.push_back('{rob_id: 5'd3, op: 3'd0, v1: 32'd5, v2: 32'd7});
        tick();
        _issue_valid = 1'b0;
        tick();
        check("basic_ready", 64'(_alu_ready), 64'd1);
        tick();
        check("basic_ready_drop", 64'(_alu_ready), 64'd0);

        // Wake-up via LSB CDB
        set_issue(5'd4, 3'd1, 1'b1, 5'd9, 32'd0, 1'b0, 5'd0, 32'd1);
        tick();
        _issue_valid = 1'b0;
        tick();
        check("wait_lsb_no_dispatch", 64'(_alu_ready), 64'd0);
        _lsb_cdb_ready = 1'b1; _lsb_cdb_rob_id = 5'd9; _lsb_cdb_value = 32'h100;
        sb_q.push_back('{rob_id: 5'd4, op: 3'd1, v1: 32'h100, v2: 32'd1});
        tick();
        _lsb_cdb_ready = 1'b0;
        check("lsb_no_same_cycle", 64'(_alu_ready), 64'd0);
        tick();
        check("lsb_wake_ready", 64'(_alu_ready), 64'd1);

        // Wake-up via ALU CDB
        set_issue(5'd5, 3'd1, 1'b1, 5'd9, 32'd0, 1'b0, 5'd0, 32'd1);
        tick();
        _issue_valid = 1'b0;
        tick();
        check("wait_alu_no_dispatch", 64'(_alu_ready), 64'd0);
        _alu_cdb_ready = 1'b1; _alu_cdb_rob_id = 5'd9; _alu_cdb_value = 32'h100;
        sb_q.push_back('{rob_id: 5'd5, op: 3'd1, v1: 32'h100, v2: 32'd1});
        tick();
        _alu_cdb_ready = 1'b0;
        tick();
        check("alu_wake_ready", 64'(_alu_ready), 64'd1);

        // Same-cycle bypass on operand 2
        set_issue(5'd6, 3'd2, 1'b0, 5'd0, 32'd11, 1'b1, 5'd2, 32'd0);
        _alu_cdb_ready = 1'b1; _alu_cdb_rob_id = 5'd2; _alu_cdb_value = 32'd42;
        sb_q.push_back('{rob_id: 5'd6, op: 3'd2, v1: 32'd11, v2: 32'd42});
        tick();
        _issue_valid = 1'b0;
        _alu_cdb_ready = 1'b0;
        tick();
        check("bypass_ready", 64'(_alu_ready), 64'd1);
        tick();

        // Fill under back-pressure, then drain in index order
        _alu_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("fill_not_full", 64'(_rs_full), 64'd0);
            set_issue(5'(16 + i), 3'(i), 1'b0, 5'd0, 32'(i), 1'b0, 5'd0, 32'(i * 3));
            tick();
        end
        _issue_valid = 1'b0;
        check("fill_full", 64'(_rs_full), 64'd1);
        check("fill_no_dispatch", 64'(_alu_ready), 64'd0);
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back('{rob_id: 5'(16 + i), op: 3'(i), v1: 32'(i), v2: 32'(i * 3)});
        end
        _alu_full = 1'b0;
        tick();
        check("drain_first_ready", 64'(_alu_ready), 64'd1);
        check("drain_full_falls", 64'(_rs_full), 64'd0);
        repeat (7) tick();
        tick();
        check("drain_done", 64'(_alu_ready), 64'd0);

        // Flush with a same-cycle issue that must be dropped
        _alu_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_issue(5'(1 + i), 3'd0, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd2);
            tick();
        end
        set_issue(5'd30, 3'd7, 1'b0, 5'd0, 32'd3, 1'b0, 5'd0, 32'd4);
        _clear = 1'b1;
        tick();
        _clear = 1'b0;
        _issue_valid = 1'b0;
        check("flush_rs_full", 64'(_rs_full), 64'd0);
        check("flush_no_ready", 64'(_alu_ready), 64'd0);
        _alu_full = 1'b0;
        repeat (4) tick();

        // Stall with a ready entry and a pending CDB match
        _alu_full = 1'b1;
        set_issue(5'd20, 3'd3, 1'b0, 5'd0, 32'hAAAA, 1'b0, 5'd0, 32'h5555);
        tick();
        set_issue(5'd21, 3'd4, 1'b1, 5'd7, 32'd0, 1'b0, 5'd0, 32'd9);
        tick();
        _issue_valid = 1'b0;
        rdy_in = 1'b0;
        _alu_full = 1'b0;
        _alu_cdb_ready = 1'b1; _alu_cdb_rob_id = 5'd7; _alu_cdb_value = 32'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ready_frozen", 64'(_alu_ready), 64'd0);
            check("stall_rob_frozen", 64'(_alu_rob_id), 64'd23);
        end
        sb_q.push_back('{rob_id: 5'd20, op: 3'd3, v1: 32'hAAAA, v2: 32'h5555});
        sb_q.push_back('{rob_id: 5'd21, op: 3'd4, v1: 32'h77, v2: 32'd9});
        rdy_in = 1'b1;
        tick();
        _alu_cdb_ready = 1'b0;
        check("resume_ready", 64'(_alu_ready), 64'd1);
        check("resume_rob", 64'(_alu_rob_id), 64'd20);
        tick();
        check("resume_woken_rob", 64'(_alu_rob_id), 64'd21);

        // Reset mid-run with a buffered entry
        _alu_full = 1'b1;
        set_issue(5'd25, 3'd5, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd1);
        tick();
        _issue_valid = 1'b0;
        rst_in = 1'b1;
        tick();
        check("rst_alu_ready", 64'(_alu_ready), 64'd0);
        check("rst_rob_id", 64'(_alu_rob_id), 64'd0);
        check("rst_op", 64'(_alu_op), 64'd0);
        check("rst_v1", 64'(_alu_v1), 64'd0);
        check("rst_v2", 64'(_alu_v2), 64'd0);
        check("rst_rs_full", 64'(_rs_full), 64'd0);
        rst_in = 1'b0;
        _alu_full = 1'b0;
        repeat (4) tick();

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
